// File: rtl/apb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_arbiter
// Purpose  : Shares one APB peripheral bus among NB_REQ requesters. Picks a
//            requester round-robin, runs the APB SETUP/ACCESS sequence and
//            returns read data and error to the granted requester. Addresses
//            outside [APB_BASE_ADDR, APB_END_ADDR] are answered with an error
//            and never reach the bus.
// Ports    : clk, rst              clock, synchronous active-high reset
//            req_i/addr_i/wdata_i/we_i   requester side, slice i per requester
//            gnt_o                 one-hot grant pulse (combinational, IDLE)
//            rvalid_o/rdata_o/err_o      one-hot completion + response data
//            paddr/pwdata/pwrite/psel/penable   APB master outputs
//            prdata/pready/pslverr APB slave responses
// Options  : APB_ARB_TIMEOUT_EN    abort ACCESS after TIMEOUT_CYCLES cycles
//                                  without pready, answering with an error
// Revision : 1.0  initial release
// ============================================================================
module apb_master_arbiter #(
  parameter int                        NB_REQ         = 2,
  parameter int                        APB_ADDR_WIDTH = 32,
  parameter int                        APB_DATA_WIDTH = 32,
  parameter logic [APB_ADDR_WIDTH-1:0] APB_BASE_ADDR  = 32'h1A10_0000,
  parameter logic [APB_ADDR_WIDTH-1:0] APB_END_ADDR   = 32'h1A11_7FFF,
  parameter int                        TIMEOUT_CYCLES = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NB_REQ-1:0]                  req_i,
  input  logic [NB_REQ*APB_ADDR_WIDTH-1:0]   addr_i,
  input  logic [NB_REQ*APB_DATA_WIDTH-1:0]   wdata_i,
  input  logic [NB_REQ-1:0]                  we_i,
  output logic [NB_REQ-1:0]                  gnt_o,
  output logic [NB_REQ-1:0]                  rvalid_o,
  output logic [APB_DATA_WIDTH-1:0]          rdata_o,
  output logic                               err_o,
  output logic [APB_ADDR_WIDTH-1:0]          paddr,
  output logic [APB_DATA_WIDTH-1:0]          pwdata,
  output logic                               pwrite,
  output logic                               psel,
  output logic                               penable,
  input  logic [APB_DATA_WIDTH-1:0]          prdata,
  input  logic                               pready,
  input  logic                               pslverr
);

  localparam int                 c_PTR_W  = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
  localparam logic [c_PTR_W:0]   c_NB_REQ = (c_PTR_W+1)'(NB_REQ);

  if (NB_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("apb_master_arbiter: NB_REQ must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ACCESS = 3'd2,
    S_RESP   = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;

  logic [c_PTR_W-1:0]         r_rr_ptr;
  logic [NB_REQ-1:0]          r_owner_oh;
  logic [APB_ADDR_WIDTH-1:0]  r_addr;
  logic [APB_DATA_WIDTH-1:0]  r_wdata;
  logic                       r_we;
  logic [APB_DATA_WIDTH-1:0]  r_rdata;
  logic                       r_err;

  logic [2*NB_REQ-1:0]        w_req_dbl;
  logic [NB_REQ-1:0]          w_req_rot;
  logic [c_PTR_W-1:0]         w_off;
  logic [c_PTR_W:0]           w_sum;
  logic [c_PTR_W-1:0]         w_win;
  logic [NB_REQ-1:0]          w_win_oh;
  logic [c_PTR_W:0]           w_inc;
  logic [c_PTR_W-1:0]         w_rr_nxt;
  logic                       w_grant;
  logic [APB_ADDR_WIDTH-1:0]  w_sel_addr;
  logic [APB_DATA_WIDTH-1:0]  w_sel_wdata;
  logic                       w_sel_we;
  logic                       w_legal;
  logic                       w_timeout;

  // Rotate the request vector so the RR pointer sits at bit 0; the lowest set
  // bit of the rotated vector is then the offset of the winner from the pointer.
  assign w_req_dbl = {req_i, req_i};
  assign w_req_rot = w_req_dbl[r_rr_ptr +: NB_REQ];

  always_comb begin
    w_off = '0;
    for (int k = NB_REQ - 1; k >= 0; k--) begin
      if (w_req_rot[k]) begin
        w_off = c_PTR_W'(k);
      end
    end
    w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
    if (w_sum >= c_NB_REQ) begin
      w_sum = w_sum - c_NB_REQ;
    end
    w_win = w_sum[c_PTR_W-1:0];
    w_win_oh = '0;
    for (int k = 0; k < NB_REQ; k++) begin
      w_win_oh[k] = (w_win == c_PTR_W'(k));
    end
    w_inc = {1'b0, w_win} + 1'b1;
    if (w_inc >= c_NB_REQ) begin
      w_inc = '0;
    end
    w_rr_nxt = w_inc[c_PTR_W-1:0];
  end

  // AND-OR mux of the winning requester's payload.
  always_comb begin
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_we    = 1'b0;
    for (int k = 0; k < NB_REQ; k++) begin
      w_sel_addr  = w_sel_addr  | (addr_i[k*APB_ADDR_WIDTH +: APB_ADDR_WIDTH] & {APB_ADDR_WIDTH{w_win_oh[k]}});
      w_sel_wdata = w_sel_wdata | (wdata_i[k*APB_DATA_WIDTH +: APB_DATA_WIDTH] & {APB_DATA_WIDTH{w_win_oh[k]}});
      w_sel_we    = w_sel_we    | (we_i[k] & w_win_oh[k]);
    end
  end

  assign w_legal = (w_sel_addr >= APB_BASE_ADDR) && (w_sel_addr <= APB_END_ADDR);

  // No grant while reset is held: the request would be lost at the reset edge.
  assign w_grant = (r_state == S_IDLE) && (|req_i) && !rst;
  assign gnt_o   = w_grant ? w_win_oh : '0;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int                 c_TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_TO_W-1:0]  c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);

  logic [c_TO_W-1:0] r_to_cnt;

  // Cleared during SETUP so it starts at zero on the first ACCESS cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (r_state == S_SETUP) begin
      r_to_cnt <= '0;
    end else if (r_state == S_ACCESS && !pready) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == S_ACCESS) && !pready && (r_to_cnt == c_TO_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_grant) w_state_nxt = w_legal ? S_SETUP : S_ERR;
      S_SETUP:  w_state_nxt = S_ACCESS;
      S_ACCESS: if (pready || w_timeout) w_state_nxt = S_RESP;
      S_RESP:   w_state_nxt = S_IDLE;
      S_ERR:    w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Only legal requests load the bus registers, so a rejected address never
  // appears on paddr. The response registers double as the hold value of
  // rdata_o/err_o between completions.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr   <= '0;
      r_owner_oh <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_grant) begin
        r_rr_ptr   <= w_rr_nxt;
        r_owner_oh <= w_win_oh;
        if (w_legal) begin
          r_addr  <= w_sel_addr;
          r_wdata <= w_sel_wdata;
          r_we    <= w_sel_we;
        end else begin
          r_rdata <= '0;
          r_err   <= 1'b1;
        end
      end
      if (r_state == S_ACCESS) begin
        if (pready) begin
          r_rdata <= r_we ? '0 : prdata;
          r_err   <= pslverr;
        end else if (w_timeout) begin
          r_rdata <= '0;
          r_err   <= 1'b1;
        end
      end
    end
  end

  assign psel     = (r_state == S_SETUP) || (r_state == S_ACCESS);
  assign penable  = (r_state == S_ACCESS);
  assign paddr    = r_addr;
  assign pwdata   = r_wdata;
  assign pwrite   = r_we;
  assign rvalid_o = ((r_state == S_RESP) || (r_state == S_ERR)) ? r_owner_oh : '0;
  assign rdata_o  = r_rdata;
  assign err_o    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_master_arbiter
// Purpose  : Self-checking bench for apb_master_arbiter. A transaction-level
//            model (cycles since grant, completion cycle) predicts every
//            output each cycle; directed sequences pin exact literal values.
// Revision : 1.0  initial release
// ============================================================================
module tb_apb_master_arbiter;

  localparam int          N    = 2;
  localparam int          AW   = 32;
  localparam int          DW   = 32;
  localparam int          TO   = 16;
  localparam logic [31:0] BASE = 32'h1A10_0000;
  localparam logic [31:0] ENDA = 32'h1A11_7FFF;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_i, we_i, gnt_o, rvalid_o;
  logic [N*AW-1:0] addr_i;
  logic [N*DW-1:0] wdata_i;
  logic [DW-1:0]   rdata_o, pwdata, prdata;
  logic [AW-1:0]   paddr;
  logic            err_o, pwrite, psel, penable, pready, pslverr;

  always #5 clk = ~clk;

  apb_master_arbiter #(
    .NB_REQ(N), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW),
    .APB_BASE_ADDR(BASE), .APB_END_ADDR(ENDA), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .we_i(we_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .err_o(err_o), .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
    .psel(psel), .penable(penable), .prdata(prdata), .pready(pready),
    .pslverr(pslverr)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  bit          m_sync = 1'b0;
  int          m_rr = 0, m_k = 0, m_who = 0, m_done_k = 0;
  bit          m_busy = 1'b0, m_legal = 1'b0, m_done = 1'b0, m_we = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rd = '0;
  logic        m_er = 1'b0;
  logic [N-1:0] m_gnt_pub = '0;

  always @(negedge clk) begin : compare
    logic [N-1:0] e_gnt, e_rv;
    logic         e_psel, e_pen;
    int           w;
    e_gnt = '0;
    if (!m_busy) begin
      for (int j = 0; j < N; j++) begin
        w = (m_rr + j) % N;
        if (req_i[w] && e_gnt == '0) e_gnt[w] = 1'b1;
      end
    end
    e_psel = m_busy && m_legal && (m_k == 1 || !m_done);
    e_pen  = m_busy && m_legal && (m_k >= 2) && !m_done;
    e_rv   = '0;
    if (m_busy && ((!m_legal && m_k == 1) || (m_legal && m_done && m_k == m_done_k + 1)))
      e_rv[m_who] = 1'b1;

    if (m_sync) begin
      if (!rst) chk("gnt", gnt_o, e_gnt);
      chk("psel", psel, e_psel);
      chk("penable", penable, e_pen);
      chk("rvalid", rvalid_o, e_rv);
      chk("rdata", rdata_o, m_rd);
      chk("err", err_o, m_er);
      if (e_psel) begin
        chk("paddr", paddr, m_addr);
        chk("pwdata", pwdata, m_wdata);
        chk("pwrite", pwrite, m_we);
      end
    end
    m_gnt_pub = rst ? '0 : e_gnt;

    if (rst) begin
      m_sync = 1'b1; m_rr = 0; m_busy = 1'b0; m_rd = '0; m_er = 1'b0;
    end else if (!m_busy) begin
      if (e_gnt != '0) begin
        for (int j = 0; j < N; j++) if (e_gnt[j]) m_who = j;
        m_addr  = addr_i[m_who*AW +: AW];
        m_wdata = wdata_i[m_who*DW +: DW];
        m_we    = we_i[m_who];
        m_legal = (m_addr >= BASE) && (m_addr <= ENDA);
        m_busy  = 1'b1; m_k = 1; m_done = 1'b0;
        m_rr    = (m_who + 1) % N;
        if (!m_legal) begin m_rd = '0; m_er = 1'b1; end
      end
    end else begin
      if (!m_legal) m_busy = 1'b0;
      else if (m_k >= 2 && !m_done) begin
        if (pready) begin
          m_done = 1'b1; m_done_k = m_k;
          m_rd = m_we ? 32'h0 : prdata; m_er = pslverr;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (m_k - 2 == TO - 1) begin
          m_done = 1'b1; m_done_k = m_k; m_rd = '0; m_er = 1'b1;
        end
`endif
      end else if (m_done) m_busy = 1'b0;
      m_k++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();   @(posedge clk); #1; endtask
  task automatic sample(); @(negedge clk); #1; endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] d, input logic w);
    addr_i[i*AW +: AW]  = a;
    wdata_i[i*DW +: DW] = d;
    we_i[i]  = w;
    req_i[i] = 1'b1;
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] a;
    case ($urandom_range(0, 6))
      0: a = BASE;
      1: a = ENDA;
      2: a = BASE - 32'd4;
      3: a = ENDA + 32'd1;
      4: a = $urandom;
      default: a = BASE + ($urandom % (ENDA - BASE + 32'd1));
    endcase
    return a;
  endfunction

  bit          pend [N];
  logic [31:0] pa [N], pd [N];
  bit          pw [N];

  initial begin
    int order [$];
    int exp3 [4];
    int acc;
    bit rv_seen, rv_err;
    exp3 = '{0, 1, 0, 1};

    rst = 1'b1; req_i = '0; addr_i = '0; wdata_i = '0; we_i = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    repeat (3) tick();
    sample();
    chk("rst_psel", psel, 0);     chk("rst_penable", penable, 0);
    chk("rst_paddr", paddr, 0);   chk("rst_pwdata", pwdata, 0);
    chk("rst_pwrite", pwrite, 0); chk("rst_rvalid", rvalid_o, 0);
    chk("rst_rdata", rdata_o, 0); chk("rst_err", err_o, 0);
    chk("rst_gnt", gnt_o, 0);

    // zero-wait read from requester 0
    tick(); rst = 1'b0; set_req(0, 32'h1A10_1000, 32'h0, 1'b0);
    pready = 1'b1; prdata = 32'h1234_5678; pslverr = 1'b0;
    sample(); chk("t1_gnt", gnt_o, 2'b01);
    tick(); req_i = '0;
    sample(); chk("t1_setup_psel", psel, 1); chk("t1_setup_pen", penable, 0);
    chk("t1_paddr", paddr, 32'h1A10_1000);
    tick(); sample(); chk("t1_access_pen", penable, 1);
    tick(); sample(); chk("t1_rvalid", rvalid_o, 2'b01);
    chk("t1_rdata", rdata_o, 32'h1234_5678); chk("t1_err", err_o, 0);

    // write from requester 1 with three wait states
    tick(); set_req(1, 32'h1A10_7004, 32'hA5A5_A5A5, 1'b1); pready = 1'b0;
    sample(); chk("t2_gnt", gnt_o, 2'b10);
    tick(); req_i = '0; sample();
    for (int c = 2; c <= 5; c++) begin
      tick(); pready = (c == 5); sample();
      chk("t2_pen", penable, 1); chk("t2_paddr", paddr, 32'h1A10_7004);
      chk("t2_pwdata", pwdata, 32'hA5A5_A5A5); chk("t2_pwrite", pwrite, 1);
    end
    tick(); pready = 1'b0; sample();
    chk("t2_rvalid", rvalid_o, 2'b10); chk("t2_err", err_o, 0); chk("t2_rdata", rdata_o, 0);

    // out-of-range addresses, then the inclusive top address
    tick(); set_req(0, 32'h1A12_0000, 32'h0, 1'b0); sample(); chk("t4a_gnt", gnt_o, 2'b01);
    tick(); req_i = '0; sample();
    chk("t4a_psel", psel, 0); chk("t4a_rvalid", rvalid_o, 2'b01);
    chk("t4a_err", err_o, 1); chk("t4a_rdata", rdata_o, 0);
    tick(); set_req(1, 32'h1A0F_FFFC, 32'h0, 1'b0); sample(); chk("t4b_gnt", gnt_o, 2'b10);
    tick(); req_i = '0; sample();
    chk("t4b_psel", psel, 0); chk("t4b_rvalid", rvalid_o, 2'b10); chk("t4b_err", err_o, 1);
    tick(); set_req(0, 32'h1A11_7FFF, 32'h0, 1'b0); pready = 1'b1; prdata = 32'hCAFE_F00D;
    sample(); chk("t4c_gnt", gnt_o, 2'b01);
    tick(); req_i = '0; sample(); chk("t4c_psel", psel, 1); chk("t4c_paddr", paddr, 32'h1A11_7FFF);
    tick(); tick(); sample();
    chk("t4c_rvalid", rvalid_o, 2'b01); chk("t4c_err", err_o, 0); chk("t4c_rdata", rdata_o, 32'hCAFE_F00D);

    // slave error on a read
    tick(); set_req(1, 32'h1A10_0010, 32'h0, 1'b0); pslverr = 1'b1; prdata = 32'h0BAD_0001;
    sample(); chk("t5_gnt", gnt_o, 2'b10);
    tick(); req_i = '0; tick(); tick(); sample();
    chk("t5_rvalid", rvalid_o, 2'b10); chk("t5_err", err_o, 1); chk("t5_rdata", rdata_o, 32'h0BAD_0001);

    // reset during ACCESS, then both requesters held for four transfers
    tick(); set_req(0, 32'h1A10_0020, 32'h0, 1'b0); pslverr = 1'b0; pready = 1'b0;
    sample(); chk("t5r_gnt", gnt_o, 2'b01);
    tick(); req_i = '0;
    tick(); rst = 1'b1; sample(); chk("t5r_pen", penable, 1);
    tick(); rst = 1'b0; pready = 1'b1; prdata = 32'h5555_AAAA;
    set_req(0, 32'h1A10_0100, 32'h1111_0000, 1'b0);
    set_req(1, 32'h1A10_0200, 32'h2222_0000, 1'b1);
    sample(); chk("t5r_psel", psel, 0); chk("t5r_rvalid", rvalid_o, 0);
    chk("t5r_gnt_after", gnt_o, 2'b01);
    order.push_back(0);
    for (int c = 0; c < 15; c++) begin
      tick(); sample();
      if (gnt_o == 2'b01) order.push_back(0);
      else if (gnt_o == 2'b10) order.push_back(1);
    end
    tick(); req_i = '0;
    chk("t3_count", order.size(), 4);
    if (order.size() >= 4)
      for (int i = 0; i < 4; i++) chk("t3_order", order[i], exp3[i]);

    // pready stuck low
    tick(); set_req(0, 32'h1A10_0300, 32'h0, 1'b0); pready = 1'b0; sample();
    tick(); req_i = '0;
    acc = 0; rv_seen = 1'b0; rv_err = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick(); sample();
      if (psel && penable) acc++;
      if (rvalid_o[0]) begin rv_seen = 1'b1; rv_err = err_o; end
    end
`ifdef APB_ARB_TIMEOUT_EN
    chk("t6_access_cycles", acc, TO); chk("t6_rvalid", rv_seen, 1); chk("t6_err", rv_err, 1);
`else
    chk("t6_access_cycles", acc, 40); chk("t6_rvalid", rv_seen, 0);
`endif
    tick(); pready = 1'b1;
    repeat (4) tick();

    // randomized traffic against the model
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (pend[i] && m_gnt_pub[i]) pend[i] = 1'b0;
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1; pa[i] = pick_addr(); pd[i] = $urandom; pw[i] = $urandom_range(0, 1);
        end
        req_i[i] = pend[i];
        addr_i[i*AW +: AW]  = pend[i] ? pa[i] : $urandom;
        wdata_i[i*DW +: DW] = pd[i];
        we_i[i] = pw[i];
      end
      pready  = ($urandom_range(0, 2) != 0);
      prdata  = $urandom;
      pslverr = ($urandom_range(0, 4) == 0);
      rst     = ($urandom_range(0, 199) == 0);
    end

    tick(); rst = 1'b0; req_i = '0; pready = 1'b1;
    repeat (40) tick();
    sample();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
